tmds_decoder: RTL and testbench
===============================

Name: tmds_decoder

Overview:
Receive-side counterpart of tmds_encoder for one DVI TMDS channel. Takes 10-bit parallel words from a deserializer on the pixel clock and aligns word boundaries by requesting bit slips until control tokens are found. Once aligned, decodes TMDS data and control words back to 8-bit pixel data, c0/c1 and de. One instance sits per colour channel in the dvi2rgb receive path.

Parameters:
LOCK_TOKENS, 8, consecutive valid control tokens required to declare lock
TIMEOUT, 4096, max cycles without a control token before slip (SEARCH) or lock loss (LOCKED); must exceed the longest active line
SLIP_SETTLE, 4, cycles to wait after a bitslip pulse before resuming the search

Ports:
clk  input  1  pixel clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
din  input  10  TMDS word from deserializer; din[0] is the first serial bit, same bit order as tmds_encoder dout
bitslip  output  1  one-cycle pulse asking the deserializer to shift word alignment by one bit
locked  output  1  word alignment established
dout  output  8  decoded pixel data
c0  output  1  decoded control bit 0
c1  output  1  decoded control bit 1
de  output  1  data enable (active video)

Behaviour:
- Reset (rst=0, async): state SEARCH, all counters 0, bitslip=0, locked=0, dout=0, c0=0, c1=0, de=0.
- Control tokens (din[9:0]): 1101010100 -> {c1,c0}=00; 0010101011 -> 01; 0101010100 -> 10; 1010101011 -> 11. Any other word is a data word.
- Data decode: if din[9]=1 then q=~din[7:0], else q=din[7:0]. dout[0]=q[0]. For i=1..7: dout[i]=q[i]^q[i-1] when din[8]=1, or ~(q[i]^q[i-1]) when din[8]=0.
- Pipeline: stage 1 registers din plus token classification; stage 2 registers the outputs. Latency is 2 clk from din to dout/c0/c1/de.
- Output rules while locked:
  - Token word: de=0, dout=0, c0/c1 take the token value.
  - Data word: de=1, dout=decoded value, c0/c1 hold their last token value.
- Output rules while not locked: de=0, dout=0, c0=0, c1=0, regardless of din.
- FSM states: SEARCH, SLIP_WAIT, LOCKED.
- SEARCH:
  - tok_cnt counts consecutive tokens; any data word clears it to 0.
  - gap_cnt increments each cycle and clears to 0 on any token.
  - If tok_cnt reaches LOCK_TOKENS: go to LOCKED and set locked=1 on the same edge.
  - Else if gap_cnt reaches TIMEOUT: bitslip=1 for exactly one cycle, clear both counters, go to SLIP_WAIT.
  - If both conditions are true on the same cycle, lock wins and no slip is issued.
- SLIP_WAIT: count SLIP_SETTLE cycles, ignoring din, then return to SEARCH with counters cleared. bitslip is 0 throughout.
- LOCKED:
  - gap_cnt clears on any token and increments otherwise.
  - If gap_cnt reaches TIMEOUT: locked=0, go to SEARCH with counters cleared. No bitslip is issued on this transition.
  - Stray data words never drop lock on their own.
- Counter width: $clog2(TIMEOUT+1) bits, saturating; counters never wrap.
- bitslip is asserted only from SEARCH. Minimum spacing between bitslip pulses is TIMEOUT+SLIP_SETTLE+1 cycles.
- Reset asserted mid-operation clears everything immediately, including any in-flight pipeline data. The next output after reset release is the reset value.

Test Plan:
- Reset: hold rst=0, drive random din -> bitslip=0, locked=0, dout=0, c0=0, c1=0, de=0. Release rst -> outputs stay 0 until lock.
- Aligned lock plus decode: 8 x 0x354, then 0x233, then 0x0CC -> locked=1 after the 8th token. Two cycles later: de=1, dout=8'hAA for both data words (words taken from tmds_encoder for din=8'hAA). c0=c1=0 throughout.
- Token mapping when locked: drive 0x0AB, 0x154, 0x2AB (each preceded by lock) -> {c1,c0}=01, 10, 11 with de=0 after 2 cycles. c0/c1 hold across a following data word.
- Misalignment: bench deserializer model rotates the stream by 3 bits and rotates by 1 bit per bitslip pulse; blanking is token-only.
  - Each bitslip pulse is 1 cycle wide, spacing is at least TIMEOUT+SLIP_SETTLE+1.
  - locked=1 is reached after the correcting slip (7 slips for a 10-bit word rotated by 3) and exactly LOCK_TOKENS tokens.
- Lock loss: once locked, drive TIMEOUT consecutive data words (0x233) -> locked=0 on the TIMEOUT-th cycle, de=0 thereafter, no bitslip. Resumed tokens re-lock after LOCK_TOKENS.
- Async reset mid-line: while locked with de=1, pulse rst=0 for 3 ns between clock edges -> locked, de and dout clear immediately. Re-lock needs a full LOCK_TOKENS token run.

Source files
------------

// File: rtl/tmds_decoder.sv
// tmds_decoder: DVI TMDS channel receiver with word alignment by bitslip search and 2-stage decode.
// Control tokens drive the alignment FSM; data words decode once locked.
module tmds_decoder #(
   parameter int LOCK_TOKENS = 8,
   parameter int TIMEOUT     = 4096,
   parameter int SLIP_SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   output logic       bitslip,
   output logic       locked,
   output logic [7:0] dout,
   output logic       c0,
   output logic       c1,
   output logic       de
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;
   state_t state;
   logic [CW-1:0] tok_cnt, gap_cnt, tok_inc, gap_inc;
   logic [9:0] d1;
   logic t1, tok;
   logic [1:0] tv1, tv;
   logic [7:0] q, dec;
   assign tok = din == 10'h354 || din == 10'h0AB || din == 10'h154 || din == 10'h2AB;
   assign tv = din == 10'h0AB ? 2'd1 : din == 10'h154 ? 2'd2 : din == 10'h2AB ? 2'd3 : 2'd0;
   assign q = d1[9] ? ~d1[7:0] : d1[7:0];
   assign dec = {q[7:1] ^ q[6:0] ^ {7{~d1[8]}}, q[0]};
   // counters saturate at TIMEOUT so they never wrap
   assign tok_inc = tok_cnt == CW'(TIMEOUT) ? tok_cnt : tok_cnt + 1'b1;
   assign gap_inc = gap_cnt == CW'(TIMEOUT) ? gap_cnt : gap_cnt + 1'b1;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SEARCH;
         tok_cnt <= '0;
         gap_cnt <= '0;
         d1      <= '0;
         t1      <= 1'b0;
         tv1     <= 2'd0;
         bitslip <= 1'b0;
         locked  <= 1'b0;
         dout    <= '0;
         c0      <= 1'b0;
         c1      <= 1'b0;
         de      <= 1'b0;
      end else begin
         bitslip <= 1'b0;
         d1      <= din;
         t1      <= tok;
         tv1     <= tv;
         dout    <= locked && !t1 ? dec : 8'd0;
         de      <= locked && !t1;
         c0      <= locked && (t1 ? tv1[0] : c0);
         c1      <= locked && (t1 ? tv1[1] : c1);
         case (state)
            SEARCH:
               if (tok && tok_cnt >= CW'(LOCK_TOKENS - 1)) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  tok_cnt <= '0;
                  gap_cnt <= '0;
               end else if (!tok && gap_cnt >= CW'(TIMEOUT - 1)) begin
                  state   <= SLIP_WAIT;
                  bitslip <= 1'b1;
                  tok_cnt <= '0;
                  gap_cnt <= '0;
               end else begin
                  tok_cnt <= tok ? tok_inc : '0;
                  gap_cnt <= tok ? '0 : gap_inc;
               end
            // the pulse cycle plus SLIP_SETTLE cycles of settling
            SLIP_WAIT:
               if (gap_cnt >= CW'(SLIP_SETTLE)) begin
                  state   <= SEARCH;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_inc;
               end
            LOCKED:
               if (!tok && gap_cnt >= CW'(TIMEOUT - 1)) begin
                  state   <= SEARCH;
                  locked  <= 1'b0;
                  tok_cnt <= '0;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= tok ? '0 : gap_inc;
               end
            default: state <= SEARCH;
         endcase
      end
   end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed checks of reset, lock, decode, token mapping, lock loss,
// async reset and bitslip alignment against a rotating deserializer model.
module tb_tmds_decoder;
   localparam int LT = 8;
   localparam int TO = 64;
   localparam int SS = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] din = '0;
   logic       bitslip, locked, c0, c1, de;
   logic [7:0] dout;
   int total = 0, bad = 0, slips = 0, sl0;
   int o, cyc, last, nsl, lk, wide;
   logic prev;
   logic [9:0] tw [3] = '{10'h0AB, 10'h154, 10'h2AB};
   logic [1:0] te [3] = '{2'd1, 2'd2, 2'd3};
   logic [9:0] dw [4] = '{10'h100, 10'h1FF, 10'h2FF, 10'h233};
   logic [7:0] de_exp [4] = '{8'h00, 8'h01, 8'hFE, 8'hAA};

   tmds_decoder #(.LOCK_TOKENS(LT), .TIMEOUT(TO), .SLIP_SETTLE(SS)) dut (
      .clk(clk), .rst(rst), .din(din), .bitslip(bitslip), .locked(locked),
      .dout(dout), .c0(c0), .c1(c1), .de(de)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (bitslip) slips++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [9:0] w);
      din = w;
      @(negedge clk);
   endtask

   function automatic logic [9:0] rot(input logic [9:0] w, input int k);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = w[(i + k) % 10];
      return r;
   endfunction

   initial begin
      repeat (4) begin
         din = 10'($urandom);
         @(negedge clk);
         chk("rst_out", {bitslip, locked, c1, c0, de, dout}, 0);
      end
      rst = 1'b1;
      repeat (5) begin
         step(10'h233);
         chk("pre_lock", {bitslip, locked, c1, c0, de, dout}, 0);
      end
      repeat (7) step(10'h354);
      chk("lock7", locked, 0);
      step(10'h354);
      chk("lock8", locked, 1);
      step(10'h233);
      chk("tok_out", {de, c1, c0, dout}, {3'b000, 8'h00});
      step(10'h0CC);
      chk("aa1", {de, c1, c0, dout}, {3'b100, 8'hAA});
      step(10'h354);
      chk("aa2", {de, c1, c0, dout}, {3'b100, 8'hAA});
      for (int i = 0; i < 3; i++) begin
         step(tw[i]);
         step(10'h155);
         chk("tok_map", {de, c1, c0, dout}, {1'b0, te[i], 8'h00});
         step(10'h354);
         chk("tok_hold", {de, c1, c0, dout}, {1'b1, te[i], 8'hFF});
      end
      for (int i = 0; i < 4; i++) begin
         step(dw[i]);
         step(10'h354);
         chk("decode", {de, c1, c0, dout}, {3'b100, de_exp[i]});
      end
      sl0 = slips;
      for (int i = 1; i <= TO; i++) begin
         step(10'h233);
         if (i == TO - 1) chk("hold_lock", locked, 1);
      end
      chk("lost", locked, 0);
      step(10'h354);
      chk("de_off", {de, dout}, 0);
      chk("no_slip", slips - sl0, 0);
      repeat (6) step(10'h354);
      chk("relock7", locked, 0);
      step(10'h354);
      chk("relock8", locked, 1);
      step(10'h233);
      step(10'h233);
      chk("pre_rst_de", {de, dout}, {1'b1, 8'hAA});
      #1 rst = 1'b0;
      #1 chk("async_clr", {locked, de, dout}, 0);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("post_rst", {locked, de, c1, c0, dout}, 0);
      repeat (7) step(10'h354);
      chk("rst_relock7", locked, 0);
      step(10'h354);
      chk("rst_relock8", locked, 1);
      rst = 1'b0;
      step(10'h233);
      rst = 1'b1;
      o = 3; cyc = 0; last = 0; nsl = 0; lk = -1; wide = 0; prev = 1'b0;
      while (lk < 0 && cyc < 10 * (TO + SS + 1) + LT + 50) begin
         din = rot(10'h354, o);
         @(negedge clk);
         cyc++;
         if (bitslip) begin
            if (prev) wide++;
            else begin
               if (nsl > 0) chk("slip_gap", cyc - last, TO + SS + 1);
               nsl++;
               last = cyc;
               o = (o + 1) % 10;
            end
         end
         prev = bitslip;
         if (locked) lk = cyc;
      end
      chk("slip_cnt", nsl, 7);
      chk("slip_wide", wide, 0);
      chk("lock_seen", lk >= 0, 1);
      chk("lock_lat", lk - last, SS + 1 + LT);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
